// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element MAC: activation encoding and
// saturation-limit helpers for signed fields of arbitrary width.
package pe_pkg;

  typedef enum logic [1:0] {
    ACT_RAW  = 2'd0,
    ACT_RELU = 2'd1,
    ACT_CLIP = 2'd2,
    ACT_RSV  = 2'd3
  } act_mode_e;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/pe_act.sv
// Combinational activation: raw, ReLU, or clip to the positive range of a
// W_IN-bit signed value. The reserved encoding passes the value through.
module pe_act
  import pe_pkg::*;
#(
  parameter int W_ACC = 24,
  parameter int W_IN  = 8
) (
  input  logic signed [W_ACC-1:0] acc_in,
  input  act_mode_e               mode,
  output logic signed [W_ACC-1:0] act_out
);

  localparam logic signed [W_ACC-1:0] CLIP_HI = W_ACC'(sat_max(W_IN));

  always_comb begin
    act_out = acc_in;
    case (mode)
      ACT_RELU: if (acc_in[W_ACC-1]) act_out = '0;
      ACT_CLIP: begin
        if (acc_in[W_ACC-1])        act_out = '0;
        else if (acc_in > CLIP_HI)  act_out = CLIP_HI;
      end
      default: act_out = acc_in;
    endcase
  end

endmodule

// File: rtl/pe_mac_lanes.sv
// Multi-lane unsigned-by-signed dot-product engine: product, lane-sum and
// saturating-accumulate stages, with a single global stall from the output.
module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W_IN  = 8,
  parameter int W_ACC = 24,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*W_IN-1:0]   a_vec,
  input  logic [LANES*W_IN-1:0]   b_vec,
  input  logic [CNT_W-1:0]        cfg_len,
  input  logic [1:0]              act_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_ACC-1:0] out_data,
  output logic                    out_sat
);

  localparam int P_W = 2 * W_IN + 1;
  localparam int S_W = P_W + $clog2(LANES);
  localparam int E_W = ((W_ACC > S_W) ? W_ACC : S_W) + 1;

  function automatic logic signed [P_W-1:0] lane_mul(input logic [W_IN-1:0] a,
                                                     input logic [W_IN-1:0] b);
    logic signed [P_W-1:0] ax;
    logic signed [P_W-1:0] bx;
    ax = $signed({{(P_W - W_IN){1'b0}}, a});
    bx = $signed({{(P_W - W_IN){b[W_IN-1]}}, b});
    return ax * bx;
  endfunction

  function automatic logic signed [W_ACC-1:0] sat_acc(input logic signed [E_W-1:0] v);
    if (v > E_W'(sat_max(W_ACC))) return W_ACC'(sat_max(W_ACC));
    if (v < E_W'(sat_min(W_ACC))) return W_ACC'(sat_min(W_ACC));
    return W_ACC'(v);
  endfunction

  logic                    en;
  logic                    accept;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        len_q;
  logic [CNT_W-1:0]        len_eff;
  act_mode_e               mode_q;
  act_mode_e               mode_cur;
  logic                    first_beat;
  logic                    last_beat;

  logic signed [P_W-1:0]   prod [LANES];
  logic signed [P_W-1:0]   prod_p0 [LANES];
  logic                    vld_p0, first_p0, last_p0;
  act_mode_e               mode_p0;

  logic signed [S_W-1:0]   lane_sum;
  logic signed [S_W-1:0]   sum_p1;
  logic                    vld_p1, first_p1, last_p1;
  act_mode_e               mode_p1;

  logic signed [E_W-1:0]   acc_ext;
  logic signed [W_ACC-1:0] acc_next;
  logic signed [W_ACC-1:0] acc_p2;
  logic signed [W_ACC-1:0] act_val;
  logic                    sat_p2;
  logic                    sat_next;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Configuration is taken from the first beat and held for the rest of the dot product
  assign first_beat = (beat_cnt == '0);
  always_comb begin
    len_eff  = first_beat ? cfg_len : len_q;
    if (len_eff == '0) len_eff = CNT_W'(1);
    mode_cur = first_beat ? act_mode_e'(act_mode) : mode_q;
  end
  assign last_beat = (beat_cnt == len_eff - CNT_W'(1));

  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod[i] = lane_mul(a_vec[i*W_IN +: W_IN], b_vec[i*W_IN +: W_IN]);
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + S_W'(prod_p0[i]);
  end

  // First beat seeds the accumulator, so no clear is needed between dot products
  always_comb begin
    acc_ext  = first_p1 ? E_W'(sum_p1) : E_W'(acc_p2) + E_W'(sum_p1);
    acc_next = sat_acc(acc_ext);
    sat_next = (!first_p1 && sat_p2) || (acc_ext != E_W'(acc_next));
  end

  pe_act #(.W_ACC(W_ACC), .W_IN(W_IN)) u_act (
    .acc_in  (acc_next),
    .mode    (mode_p1),
    .act_out (act_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      len_q     <= '0;
      mode_q    <= ACT_RAW;
      vld_p0    <= 1'b0;
      first_p0  <= 1'b0;
      last_p0   <= 1'b0;
      mode_p0   <= ACT_RAW;
      for (int i = 0; i < LANES; i++) prod_p0[i] <= '0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      mode_p1   <= ACT_RAW;
      sum_p1    <= '0;
      acc_p2    <= '0;
      sat_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
        if (first_beat) begin
          len_q  <= len_eff;
          mode_q <= mode_cur;
        end
      end
      // S1: per-lane products
      vld_p0   <= accept;
      first_p0 <= first_beat;
      last_p0  <= last_beat;
      mode_p0  <= mode_cur;
      for (int i = 0; i < LANES; i++) prod_p0[i] <= prod[i];
      // S2: full-width lane sum
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      mode_p1  <= mode_p0;
      sum_p1   <= lane_sum;
      // S3: saturating accumulate and activated result
      if (vld_p1) begin
        acc_p2 <= acc_next;
        sat_p2 <= sat_next;
      end
      out_valid <= vld_p1 && last_p1;
      if (vld_p1 && last_p1) begin
        out_data <= act_val;
        out_sat  <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_lanes.sv
// Randomized and directed bench for pe_mac_lanes against a plain-arithmetic
// dot-product model with a result scoreboard.
module tb_pe_mac_lanes;

  localparam int LANES = 4;
  localparam int W_IN  = 8;
  localparam int W_ACC = 24;
  localparam int CNT_W = 8;
  localparam longint ACC_MAX = 8388607;
  localparam longint ACC_MIN = -8388608;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*W_IN-1:0]   a_vec = '0;
  logic [LANES*W_IN-1:0]   b_vec = '0;
  logic [CNT_W-1:0]        cfg_len = '0;
  logic [1:0]              act_mode = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [W_ACC-1:0] out_data;
  logic                    out_sat;

  pe_mac_lanes #(.LANES(LANES), .W_IN(W_IN), .W_ACC(W_ACC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .cfg_len   (cfg_len),
    .act_mode  (act_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint data;
    longint sat;
    longint stamp;
  } exp_t;

  exp_t   expq[$];
  int     mcnt = 0;
  int     mlen = 1;
  int     mmode = 0;
  longint macc = 0;
  longint msat = 0;
  longint en_cnt = 0;
  bit     shown = 0;
  longint last_data = 0;
  longint last_sat = 0;
  int     n_results = 0;
  int     or_mode = 0;

  function automatic longint activate(input longint v, input int mode);
    if (mode == 1) return (v < 0) ? 0 : v;
    if (mode == 2) return (v < 0) ? 0 : ((v > 127) ? 127 : v);
    return v;
  endfunction

  task automatic model_accept();
    longint s;
    exp_t   e;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      int av;
      int bv;
      av = int'(a_vec[i*W_IN +: W_IN]);
      bv = int'($signed(b_vec[i*W_IN +: W_IN]));
      s += longint'(av) * longint'(bv);
    end
    if (mcnt == 0) begin
      mlen  = (cfg_len == 0) ? 1 : int'(cfg_len);
      mmode = int'(act_mode);
      macc  = s;
      msat  = 0;
    end else begin
      macc += s;
    end
    if (macc > ACC_MAX) begin macc = ACC_MAX; msat = 1; end
    if (macc < ACC_MIN) begin macc = ACC_MIN; msat = 1; end
    mcnt++;
    if (mcnt == mlen) begin
      e.data  = activate(macc, mmode);
      e.sat   = msat;
      e.stamp = en_cnt;
      expq.push_back(e);
      mcnt = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !shown) begin
        shown = 1;
        if (expq.size() == 0) chk("spurious_out", 1, 0);
        else chk("latency", en_cnt - expq[0].stamp, 3);
      end
      if (out_valid && out_ready) begin
        if (expq.size() != 0) begin
          exp_t e;
          e = expq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sat", out_sat, e.sat);
        end
        last_data = out_data;
        last_sat  = out_sat;
        shown = 0;
        n_results++;
      end
      if (in_valid && in_ready) model_accept();
      if (in_ready) en_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (or_mode == 0)      out_ready = 1'b1;
    else if (or_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
    else                   out_ready = 1'b0;
  end

  function automatic logic [31:0] rep(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {4{b}};
  endfunction

  task automatic set_beat(input logic [31:0] av, input logic [31:0] bv, input int len, input int mode);
    a_vec    = av;
    b_vec    = bv;
    cfg_len  = 8'(len);
    act_mode = 2'(mode);
    in_valid = 1'b1;
  endtask

  task automatic wait_acc();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] av, input logic [31:0] bv, input int len, input int mode);
    set_beat(av, bv, len, mode);
    wait_acc();
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && expq.size() != 0; k++) @(negedge clk);
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    expq.delete();
    mcnt  = 0;
    shown = 0;
  endtask

  initial begin
    int base;
    longint cap;

    // reset values
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // two-beat dot product: 4*10*3 twice
    beat(rep(10), rep(3), 2, 0);
    beat(rep(10), rep(3), 2, 0);
    drain();
    chk("dot240_data", last_data, 240);
    chk("dot240_sat", last_sat, 0);

    // cfg_len 0 behaves as 1
    beat(rep(1), rep(5), 0, 0);
    drain();
    chk("len0_data", last_data, 20);

    // activations
    beat(32'd1, {24'd0, 8'hCE}, 1, 1);
    drain();
    chk("relu_neg", last_data, 0);
    beat(32'd125, 32'd4, 1, 2);
    drain();
    chk("clip_hi", last_data, 127);
    beat(32'd15, 32'd4, 1, 2);
    drain();
    chk("clip_pass", last_data, 60);

    // negative saturation over a long dot product
    for (int i = 0; i < 200; i++) beat(rep(255), rep(-128), 200, 0);
    drain();
    chk("sat_data", last_data, -8388608);
    chk("sat_flag", last_sat, 1);

    // output stall holds data and blocks input
    or_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    beat(rep(10), rep(1), 1, 0);
    set_beat(rep(7), rep(2), 1, 0);
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = out_valid;
      end
      if (!seen) chk("stall_wait_timeout", 0, 1);
    end
    cap = out_data;
    chk("stall_first", cap, 40);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", out_data, cap);
    end
    @(posedge clk);
    #1;
    or_mode = 0;
    wait_acc();
    drain();
    chk("stall_second", last_data, 56);

    // back-to-back single-beat stream with random output stalls
    or_mode = 1;
    base = n_results;
    for (int i = 0; i < 20; i++) beat($urandom, $urandom, 1, $urandom_range(0, 3));
    drain();
    or_mode = 0;
    drain();
    chk("stream_count", n_results - base, 20);

    // reset in the middle of an 8-beat dot product
    beat(rep(9), rep(9), 1, 0);
    for (int i = 0; i < 3; i++) beat(rep(50), rep(50), 8, 0);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_sat", out_sat, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) beat(rep(2), rep(3), 8, 0);
    drain();
    chk("fresh_sum", last_data, 192);

    // random dot products with bubbles and stalls
    or_mode = 1;
    for (int i = 0; i < 80; i++) begin
      beat($urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < 10 && mcnt != 0; k++)
      beat($urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 3));
    chk("rand_complete", mcnt, 0);
    drain();
    or_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
